// File: rtl/exa_crosb_output_vc_sched_pkg.sv
// Shared types for the VC crossbar output scheduler: FSM states and credit counter type.
package exanet_crosb_pkg;

    localparam int CREDIT_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_t;

    typedef logic [CREDIT_W-1:0] credit_vec_t;

endpackage

// File: rtl/exa_crosb_output_vc_sched_if.sv
// Request/grant/credit bundle between the crossbar input side and one output scheduler.
interface exa_crosb_output_vc_sched_if
    import exanet_crosb_pkg::*;
#(
    parameter int input_num = 4,
    parameter int vc_num    = 4,
    parameter int prio_num  = 2
);
    localparam int VC_TOTAL  = prio_num * vc_num;
    localparam int logInput  = $clog2(input_num);
    localparam int logVcPrio = $clog2(VC_TOTAL);

    logic [input_num-1:0]                i_req;
    logic [input_num-1:0][logVcPrio-1:0] i_req_vc;
    logic                                i_pkt_done;
    logic [VC_TOTAL-1:0]                 i_credit_ret;
    logic [input_num-1:0]                o_grant;
    logic [logInput-1:0]                 o_input_sel;
    logic [logVcPrio-1:0]                o_selected_output_vc;
    logic                                o_busy;
    credit_vec_t [VC_TOTAL-1:0]          o_credit_cnt;
    logic                                o_credit_err;

    modport master (
        output i_req, i_req_vc, i_pkt_done, i_credit_ret,
        input  o_grant, o_input_sel, o_selected_output_vc, o_busy, o_credit_cnt, o_credit_err
    );

    modport slave (
        input  i_req, i_req_vc, i_pkt_done, i_credit_ret,
        output o_grant, o_input_sel, o_selected_output_vc, o_busy, o_credit_cnt, o_credit_err
    );

endinterface

// File: rtl/exa_crosb_output_vc_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module exa_crosb_rr_arbiter #(
    parameter  int N  = 4,
    localparam int LW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [LW-1:0] idx,
    output logic          valid
);

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[(int'(ptr) + k) % N]) begin
                valid                         = 1'b1;
                idx                           = LW'((int'(ptr) + k) % N);
                grant[(int'(ptr) + k) % N]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exa_crosb_output_vc_sched.sv
// Per-output packet scheduler: strict-priority classes, RR within class, credit-gated, locked until footer.
// Optional starvation aging enabled by defining EXA_CROSB_SCHED_AGE_EN.
module exa_crosb_output_vc_sched
    import exanet_crosb_pkg::*;
#(
    parameter int input_num    = 4,
    parameter int vc_num       = 4,
    parameter int prio_num     = 2,
    parameter int CREDITS_INIT = 4
`ifdef EXA_CROSB_SCHED_AGE_EN
    , parameter int AGE_LIMIT  = 64
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    exa_crosb_output_vc_sched_if.slave   sched
);

    localparam int VC_TOTAL  = prio_num * vc_num;
    localparam int logInput  = $clog2(input_num);
    localparam int logVcPrio = $clog2(VC_TOTAL);
    localparam int logVc     = $clog2(vc_num);
    localparam int logPrio   = (prio_num > 1) ? $clog2(prio_num) : 1;
    localparam credit_vec_t CREDIT_INIT_V = credit_vec_t'(CREDITS_INIT);

    sched_state_t                        state_reg;
    logic [input_num-1:0]                grant_reg;
    logic [logInput-1:0]                 input_sel_reg;
    logic [logVcPrio-1:0]                vc_sel_reg;
    logic                                busy_reg;
    logic [prio_num-1:0][logInput-1:0]   rr_ptr_reg;
    credit_vec_t [VC_TOTAL-1:0]          credit_reg;
    logic                                credit_err_reg;

    logic [input_num-1:0]                eligible;
    logic [input_num-1:0]                aged;
    logic [input_num-1:0][logPrio-1:0]   req_class;
    logic [prio_num-1:0][input_num-1:0]  class_req;
    logic [prio_num-1:0][input_num-1:0]  arb_grant;
    logic [prio_num-1:0][logInput-1:0]   arb_idx;
    logic [prio_num-1:0]                 arb_valid;
    logic [logPrio-1:0]                  win_class;
    logic [logInput-1:0]                 win_idx;
    logic [input_num-1:0]                win_grant;
    logic [logVcPrio-1:0]                win_vc;
    logic                                grant_fire;
    logic [VC_TOTAL-1:0]                 dec_vec;
    logic [VC_TOTAL-1:0]                 ret_full;

    genvar gi;
    generate
        for (gi = 0; gi < input_num; gi++) begin : g_req
            assign eligible[gi]  = sched.i_req[gi] && (credit_reg[sched.i_req_vc[gi]] != '0);
            assign req_class[gi] = logPrio'(sched.i_req_vc[gi] >> logVc);
        end
    endgenerate

`ifdef EXA_CROSB_SCHED_AGE_EN
    logic [input_num-1:0][6:0] age_reg;
    generate
        for (gi = 0; gi < input_num; gi++) begin : g_age
            always_ff @(posedge clk) begin
                if (reset || !sched.i_req[gi] || grant_reg[gi])
                    age_reg[gi] <= '0;
                else if (age_reg[gi] != 7'h7f)
                    age_reg[gi] <= age_reg[gi] + 7'd1;
            end
            assign aged[gi] = (age_reg[gi] >= 7'(AGE_LIMIT));
        end
    endgenerate
`else
    assign aged = '0;
`endif

    // Aged requesters are promoted into the top class so its RR pointer breaks ties.
    always_comb begin
        class_req = '0;
        for (int i = 0; i < input_num; i++) begin
            if (aged[i])
                class_req[prio_num-1][i] = eligible[i];
            else
                class_req[req_class[i]][i] = eligible[i];
        end
    end

    generate
        for (gi = 0; gi < prio_num; gi++) begin : g_arb
            exa_crosb_rr_arbiter #(.N(input_num)) u_arb (
                .req   (class_req[gi]),
                .ptr   (rr_ptr_reg[gi]),
                .grant (arb_grant[gi]),
                .idx   (arb_idx[gi]),
                .valid (arb_valid[gi])
            );
        end
    endgenerate

    always_comb begin
        win_class = '0;
        for (int p = 0; p < prio_num; p++) begin
            if (arb_valid[p])
                win_class = logPrio'(p);
        end
    end

    assign win_idx    = arb_idx[win_class];
    assign win_grant  = arb_grant[win_class];
    assign win_vc     = sched.i_req_vc[win_idx];
    assign grant_fire = (state_reg == IDLE) && (|eligible);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            input_sel_reg <= '0;
            vc_sel_reg    <= '0;
            busy_reg      <= 1'b0;
            rr_ptr_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_fire) begin
                        state_reg             <= LOCKED;
                        grant_reg             <= win_grant;
                        input_sel_reg         <= win_idx;
                        vc_sel_reg            <= win_vc;
                        busy_reg              <= 1'b1;
                        rr_ptr_reg[win_class] <= logInput'((int'(win_idx) + 1) % input_num);
                    end
                end
                LOCKED: begin
                    if (sched.i_pkt_done) begin
                        state_reg <= IDLE;
                        grant_reg <= '0;
                        busy_reg  <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        for (gi = 0; gi < VC_TOTAL; gi++) begin : g_credit
            assign dec_vec[gi]  = grant_fire && (win_vc == logVcPrio'(gi));
            assign ret_full[gi] = sched.i_credit_ret[gi] && !dec_vec[gi] &&
                                  (credit_reg[gi] == CREDIT_INIT_V);
        end
    endgenerate

    // A return and a grant on the same VC cancel; returns into a full counter saturate.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < VC_TOTAL; v++)
                credit_reg[v] <= CREDIT_INIT_V;
            credit_err_reg <= 1'b0;
        end else begin
            for (int v = 0; v < VC_TOTAL; v++) begin
                if (sched.i_credit_ret[v] && !dec_vec[v]) begin
                    if (credit_reg[v] != CREDIT_INIT_V)
                        credit_reg[v] <= credit_reg[v] + 1'b1;
                end else if (dec_vec[v] && !sched.i_credit_ret[v]) begin
                    credit_reg[v] <= credit_reg[v] - 1'b1;
                end
            end
            credit_err_reg <= credit_err_reg | (|ret_full);
        end
    end

    assign sched.o_grant              = grant_reg;
    assign sched.o_input_sel          = input_sel_reg;
    assign sched.o_selected_output_vc = vc_sel_reg;
    assign sched.o_busy               = busy_reg;
    assign sched.o_credit_cnt         = credit_reg;
    assign sched.o_credit_err         = credit_err_reg;

endmodule

// File: doc/exa_crosb_output_vc_sched.md
Name: exa_crosb_output_vc_sched

Overview:
Per-output-port packet scheduler for the VC crossbar. It arbitrates among all input ports requesting this output, and checks that the requested output VC (prio*vc_num + vc) holds a downstream credit. It locks the granted input onto the output from grant until footer handshake. It drives the crossbar mux select and the selected output VC.

Parameters:
input_num, 4, crossbar inputs competing for this output
vc_num, 4, VCs per priority class
prio_num, 2, priority classes; class index = vc_idx / vc_num, higher index wins
CREDITS_INIT, 4, per-output-VC packet credits loaded at reset (1..15)
logInput, log2(input_num), select width
logVcPrio, log2(prio_num*vc_num), output VC index width
AGE_LIMIT, 64, starvation threshold in cycles (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_req  in  input_num  per-input packet request (header waiting)
i_req_vc  in  [input_num][logVcPrio]  requested output VC per input; stable while i_req=1
i_pkt_done  in  1  footer_valid & footer_ready on this output
i_credit_ret  in  prio_num*vc_num  one-cycle pulse per output VC: downstream freed one packet slot
o_grant  out  input_num  one-hot grant, held for whole packet
o_input_sel  out  logInput  binary index of granted input
o_selected_output_vc  out  logVcPrio  VC of locked packet
o_busy  out  1  packet in flight
o_credit_cnt  out  [prio_num*vc_num][4]  current credit counters
o_credit_err  out  1  sticky: credit returned to full counter

Behaviour:
- Reset (synchronous; mid-packet too): state IDLE, o_grant=0, o_input_sel=0, o_selected_output_vc=0, o_busy=0, all counters=CREDITS_INIT, RR pointers=0, o_credit_err=0.
- Eligible(i) = i_req[i] & credit[i_req_vc[i]] != 0.
- IDLE: if any eligible, select the highest class among eligible requesters. Within that class, round-robin from rr_ptr[class]. Register the winner, so grant appears the cycle after the request is seen (1-cycle latency). Go to LOCKED. Same edge: credit[vc] -= 1; rr_ptr[class] = (winner+1) mod input_num.
- LOCKED: outputs held constant. Request changes are ignored. On i_pkt_done, go to IDLE next cycle with o_grant=0. Back-to-back packets therefore incur one idle cycle.
- i_pkt_done in IDLE is ignored.
- Requests may drop before grant without side effects.
- Credits: grant decrement and return for the same VC in the same cycle leaves the counter unchanged. A return at CREDITS_INIT saturates and sets o_credit_err. Decrement occurs only when the counter is >0 (guaranteed by eligibility).
- Zero credits on all requested VCs: stay IDLE, no grant, no pointer movement.
- Width rule: class = vc_idx / vc_num (shift when vc_num is a power of 2); RR wrap via modulo input_num.

Optional Feature:
- Macro: EXA_CROSB_SCHED_AGE_EN.
- Defined:
  - Per-input 7-bit wait counter increments while i_req & !grant, and clears on grant or request drop.
  - An input whose counter ≥ AGE_LIMIT is treated as top class.
  - Ties among aged inputs are broken by the top-class RR pointer.
- Undefined: counters absent, strict priority only (low class may starve).

Decomposition:
- Package exanet_crosb_pkg: sched_state_t enum {IDLE, LOCKED}, CREDIT_W=4 constant, credit_vec_t typedef.
- One sub-module: exa_crosb_rr_arbiter (parameterised width, request vector + pointer in, one-hot grant + index out, purely combinational), instantiated once per priority class.

Test Plan:
- Single request: i_req=0001, vc=5 → o_grant=0001 one cycle later, o_selected_output_vc=5, credit[5]=3. i_pkt_done → grant drops next cycle.
- RR fairness: all 4 inputs hold low-class vc=1 with ample credit returns → grants cycle 0,1,2,3,0 across 5 packets.
- Strict priority: input0 vc=2 and input3 vc=6 requested together → input3 granted first, input0 after its footer.
- Credit exhaustion: 4 packets on vc=0 without returns → 5th request gets no grant. One i_credit_ret[0] pulse → grant follows the next cycle.
- Simultaneous grant and return on vc=3 at count 2 → count stays 2. Return at count 4 → o_credit_err=1 and stays 1.
- Reset asserted mid-packet: next cycle o_grant=0, o_busy=0, all counters=4.
- With EXA_CROSB_SCHED_AGE_EN: input1 low-class waits 64 cycles under continuous high-class traffic → then granted.
